// File: rtl/datapath.sv
`default_nettype none
// ==========================================================================
// datapath : single-bus CPU datapath (R0..R15, special regs, ALU, Z, CON)
// Revision : 1.0
// ==========================================================================
module datapath (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Read,
  input  logic        Write,
  input  logic        IncPC,
  input  logic [15:0] R0_15_enable,
  input  logic [15:0] R0_15_out,
  input  logic        PCin,
  input  logic        Zin,
  input  logic        MDRin,
  input  logic        MARin,
  input  logic        Yin,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        IRin,
  input  logic        OutPortin,
  input  logic        PCout,
  input  logic        Zhighout,
  input  logic        Zlowout,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        MDRout,
  input  logic        InPortout,
  input  logic        Cout,
  input  logic        BAout,
  input  logic        CONin,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        Rin,
  input  logic        Rout,
  input  logic [31:0] InPort_input,
  input  logic [31:0] Mdatain
);

  // Architectural state keeps its programmer-visible names for probing.
  logic [31:0] R0, R1, R2, R3, R4, R5, R6, R7;
  logic [31:0] R8, R9, R10, R11, R12, R13, R14, R15;
  logic [31:0] PC, IR, MAR, MDR, Y, HI, LO, InPort, OutPort;
  logic [63:0] Z;
  logic        CON;

  logic [31:0] r_cur [16];
  logic [31:0] r_d   [16];
  logic [31:0] PC_d, IR_d, MAR_d, MDR_d, Y_d, HI_d, LO_d, InPort_d, OutPort_d;
  logic [63:0] Z_d;
  logic        CON_d;

  logic [15:0] r_write, r_drive;
  logic [3:0]  sel_idx;
  logic [31:0] c_sext, bus;
  logic        taken;

  assign r_cur = '{R0, R1, R2, R3, R4, R5, R6, R7,
                   R8, R9, R10, R11, R12, R13, R14, R15};

  assign sel_idx = ({4{Gra}} & IR[26:23]) | ({4{Grb}} & IR[22:19]) | ({4{Grc}} & IR[18:15]);
  assign c_sext  = {{13{IR[18]}}, IR[18:0]};

  always_comb begin
    for (int n = 0; n < 16; n++) begin
      r_write[n] = R0_15_enable[n] | (Rin  & (sel_idx == 4'(n)));
      r_drive[n] = R0_15_out[n]    | (Rout & (sel_idx == 4'(n)));
    end
  end

  // Priority bus mux: first asserted source in the fixed order wins.
  always_comb begin
    bus   = '0;
    taken = 1'b0;
    for (int n = 0; n < 16; n++) begin
      if (!taken && r_drive[n]) begin
        bus   = (n == 0 && BAout) ? 32'd0 : r_cur[n];
        taken = 1'b1;
      end
    end
    if (!taken) begin
      if      (HIout)     bus = HI;
      else if (LOout)     bus = LO;
      else if (Zhighout)  bus = Z[63:32];
      else if (Zlowout)   bus = Z[31:0];
      else if (PCout)     bus = PC;
      else if (MDRout)    bus = MDR;
      else if (InPortout) bus = InPort;
      else if (Cout)      bus = c_sext;
    end
  end

  // ALU: A comes from Y, B from the bus.
  logic [31:0]        alu_a, alu_b;
  logic [4:0]         amt;
  logic signed [63:0] prod;
  logic [63:0]        rot_r, rot_l, alu_res;
  logic signed [31:0] quo, rem;

  assign alu_a = Y;
  assign alu_b = bus;
  assign amt   = alu_b[4:0];
  assign prod  = $signed({{32{alu_a[31]}}, alu_a}) * $signed({{32{alu_b[31]}}, alu_b});
  assign rot_r = {alu_a, alu_a} >> amt;
  assign rot_l = {alu_a, alu_a} << amt;

  always_comb begin
    quo = '0;
    rem = '0;
    if (alu_b != 32'd0) begin
      quo = $signed(alu_a) / $signed(alu_b);
      rem = $signed(alu_a) % $signed(alu_b);
    end
  end

  always_comb begin
    alu_res = {32'd0, alu_b};
    case (IR[31:27])
      5'b00000, 5'b00001, 5'b00010,
      5'b00011, 5'b01100: alu_res = {32'd0, alu_a + alu_b};
      5'b00100:           alu_res = {32'd0, alu_a - alu_b};
      5'b00101, 5'b01101: alu_res = {32'd0, alu_a & alu_b};
      5'b00110, 5'b01110: alu_res = {32'd0, alu_a | alu_b};
      5'b00111:           alu_res = {32'd0, alu_a >> amt};
      5'b01000:           alu_res = {32'd0, 32'($signed(alu_a) >>> amt)};
      5'b01001:           alu_res = {32'd0, alu_a << amt};
      5'b01010:           alu_res = {32'd0, rot_r[31:0]};
      5'b01011:           alu_res = {32'd0, rot_l[63:32]};
      5'b01111:           alu_res = prod;
      5'b10000:           alu_res = {rem, quo};
      5'b10001:           alu_res = {32'd0, -alu_b};
      5'b10010:           alu_res = {32'd0, ~alu_b};
      default:            alu_res = {32'd0, alu_b};
    endcase
  end

  logic con_eval;
  always_comb begin
    case (IR[20:19])
      2'b00:   con_eval = (bus == 32'd0);
      2'b01:   con_eval = (bus != 32'd0);
      2'b10:   con_eval = ~bus[31];
      default: con_eval = bus[31];
    endcase
  end

  always_comb begin
    for (int n = 0; n < 16; n++) r_d[n] = r_write[n] ? bus : r_cur[n];
    PC_d = PC;
    if (PCin) PC_d = IncPC ? PC + 32'd1 : bus;
    IR_d      = IRin      ? bus : IR;
    MAR_d     = MARin     ? bus : MAR;
    MDR_d     = MDRin     ? (Read ? Mdatain : bus) : MDR;
    Y_d       = Yin       ? bus : Y;
    HI_d      = HIin      ? bus : HI;
    LO_d      = LOin      ? bus : LO;
    OutPort_d = OutPortin ? bus : OutPort;
    InPort_d  = InPort_input;
    Z_d       = Zin       ? alu_res : Z;
    CON_d     = CONin     ? con_eval : CON;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      R0  <= '0; R1  <= '0; R2  <= '0; R3  <= '0;
      R4  <= '0; R5  <= '0; R6  <= '0; R7  <= '0;
      R8  <= '0; R9  <= '0; R10 <= '0; R11 <= '0;
      R12 <= '0; R13 <= '0; R14 <= '0; R15 <= '0;
      PC <= '0; IR <= '0; MAR <= '0; MDR <= '0; Y <= '0;
      HI <= '0; LO <= '0; InPort <= '0; OutPort <= '0;
      Z  <= '0; CON <= 1'b0;
    end else begin
      R0  <= r_d[0];  R1  <= r_d[1];  R2  <= r_d[2];  R3  <= r_d[3];
      R4  <= r_d[4];  R5  <= r_d[5];  R6  <= r_d[6];  R7  <= r_d[7];
      R8  <= r_d[8];  R9  <= r_d[9];  R10 <= r_d[10]; R11 <= r_d[11];
      R12 <= r_d[12]; R13 <= r_d[13]; R14 <= r_d[14]; R15 <= r_d[15];
      PC <= PC_d; IR <= IR_d; MAR <= MAR_d; MDR <= MDR_d; Y <= Y_d;
      HI <= HI_d; LO <= LO_d; InPort <= InPort_d; OutPort <= OutPort_d;
      Z  <= Z_d;  CON <= CON_d;
    end
  end

  // Write, MAR, OutPort and CON are consumed outside this block.
  logic unused_ok;
  assign unused_ok = &{1'b0, Write, MAR, OutPort, CON};

endmodule
`default_nettype wire

// File: tb/tb_datapath.sv
`default_nettype none
// ==========================================================================
// tb_datapath : directed self-checking bench for datapath
// Revision    : 1.0
// ==========================================================================
module tb_datapath;

  logic        Clock = 1'b0;
  logic        Reset, Read, Write, IncPC;
  logic [15:0] R0_15_enable, R0_15_out;
  logic        PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin, OutPortin;
  logic        PCout, Zhighout, Zlowout, HIout, LOout, MDRout, InPortout, Cout;
  logic        BAout, CONin, Gra, Grb, Grc, Rin, Rout;
  logic [31:0] InPort_input, Mdatain;

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  datapath dut (
    .Clock(Clock), .Reset(Reset), .Read(Read), .Write(Write), .IncPC(IncPC),
    .R0_15_enable(R0_15_enable), .R0_15_out(R0_15_out),
    .PCin(PCin), .Zin(Zin), .MDRin(MDRin), .MARin(MARin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .IRin(IRin), .OutPortin(OutPortin),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .HIout(HIout),
    .LOout(LOout), .MDRout(MDRout), .InPortout(InPortout), .Cout(Cout),
    .BAout(BAout), .CONin(CONin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .InPort_input(InPort_input), .Mdatain(Mdatain)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic clr();
    Reset = 0; Read = 0; Write = 0; IncPC = 0;
    R0_15_enable = '0; R0_15_out = '0;
    PCin = 0; Zin = 0; MDRin = 0; MARin = 0; Yin = 0; HIin = 0; LOin = 0;
    IRin = 0; OutPortin = 0; PCout = 0; Zhighout = 0; Zlowout = 0;
    HIout = 0; LOout = 0; MDRout = 0; InPortout = 0; Cout = 0;
    BAout = 0; CONin = 0; Gra = 0; Grb = 0; Grc = 0; Rin = 0; Rout = 0;
  endtask

  // One clock edge, then sample point 1 ns later with controls released.
  task automatic step();
    @(posedge Clock);
    #1;
    clr();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1; MDRin = 1; step();
  endtask

  task automatic alu_case(input string tag, input logic [31:0] ir, input logic [31:0] y,
                          input logic [31:0] b, input logic [63:0] exp);
    load_mdr(ir); MDRout = 1; IRin = 1; step();
    load_mdr(y);  MDRout = 1; Yin  = 1; step();
    load_mdr(b);  MDRout = 1; Zin  = 1; step();
    check(tag, dut.Z, exp);
  endtask

  initial begin
    clr();
    InPort_input = 32'h0; Mdatain = 32'h0;
    #2;
    Reset = 1; Mdatain = 32'hFFFF_FFFF; Read = 1; MDRin = 1; PCin = 1; IncPC = 1;
    step();
    check("reset_mdr", dut.MDR, 64'h0);
    check("reset_pc",  dut.PC,  64'h0);
    check("reset_z",   dut.Z,   64'h0);
    check("idle_bus",  dut.bus, 64'h0);

    // Memory read into MDR then into R1
    load_mdr(32'h12);
    check("mdr_read", dut.MDR, 64'h12);
    MDRout = 1; R0_15_enable = 16'h0002; step();
    check("r1_load", dut.R1, 64'h12);

    // addi R2, R3, -3 with R3 = 0x14
    load_mdr(32'h14); MDRout = 1; R0_15_enable = 16'h0008; step();
    load_mdr(32'h611F_FFFD); MDRout = 1; IRin = 1; step();
    Grb = 1; Rout = 1; Yin = 1; step();
    check("y_from_rb", dut.Y, 64'h14);
    Cout = 1; Zin = 1; step();
    check("addi_z", dut.Z, 64'h11);
    Zlowout = 1; Gra = 1; Rin = 1; step();
    check("r2_from_ra", dut.R2, 64'h11);

    // PC load, MAR from PC, increment
    load_mdr(32'h5); MDRout = 1; PCin = 1; step();
    check("pc_load", dut.PC, 64'h5);
    PCout = 1; MARin = 1; step();
    check("mar_from_pc", dut.MAR, 64'h5);
    PCin = 1; IncPC = 1; step();
    check("pc_inc", dut.PC, 64'h6);

    // ALU operations
    alu_case("mul",      32'h7800_0000, 32'hFFFF_FFFE, 32'h3, 64'hFFFF_FFFF_FFFF_FFFA);
    alu_case("div_zero", 32'h8000_0000, 32'h7,         32'h0, 64'h0);
    alu_case("div_neg",  32'h8000_0000, 32'hFFFF_FFF9, 32'h2, 64'hFFFF_FFFF_FFFF_FFFD);
    alu_case("sub",      32'h2000_0000, 32'h5,         32'h7, 64'h0000_0000_FFFF_FFFE);
    alu_case("ror",      32'h5000_0000, 32'h1,         32'h1, 64'h0000_0000_8000_0000);
    alu_case("shra",     32'h4000_0000, 32'h8000_0000, 32'h4, 64'h0000_0000_F800_0000);
    alu_case("rol",      32'h5800_0000, 32'h8000_0001, 32'h4, 64'h0000_0000_0000_0018);
    alu_case("neg",      32'h8800_0000, 32'h0,         32'h1, 64'h0000_0000_FFFF_FFFF);

    // BAout forces R0 reads to zero; bus priority
    load_mdr(32'h55); MDRout = 1; R0_15_enable = 16'h0001; step();
    R0_15_out = 16'h0001; #1;
    check("r0_bus", dut.bus, 64'h55);
    BAout = 1; #1;
    check("r0_baout", dut.bus, 64'h0);
    clr();
    R0_15_out = 16'h000A; HIout = 1; MDRout = 1; #1;
    check("bus_priority", dut.bus, 64'h12);
    clr();

    // CON with C2 = 01 (branch if nonzero)
    load_mdr(32'h0008_0000); MDRout = 1; IRin = 1; step();
    R0_15_out = 16'h0001; CONin = 1; step();
    check("con_set", dut.CON, 64'h1);
    R0_15_out = 16'h0001; BAout = 1; CONin = 1; step();
    check("con_clear", dut.CON, 64'h0);

    // Simultaneous loads from one bus value, plus input port
    load_mdr(32'hCAFE_0001); MDRout = 1; Yin = 1; MARin = 1; R0_15_enable = 16'h0020; step();
    check("multi_y",   dut.Y,   64'hCAFE_0001);
    check("multi_mar", dut.MAR, 64'hCAFE_0001);
    check("multi_r5",  dut.R5,  64'hCAFE_0001);
    InPort_input = 32'hDEAD_BEEF; step();
    InPortout = 1; LOin = 1; step();
    check("inport_lo", dut.LO, 64'hDEAD_BEEF);

    // Reset mid-sequence overrides active enables
    Reset = 1; Mdatain = 32'hAA; Read = 1; MDRin = 1; Zin = 1; R0_15_enable = 16'hFFFF;
    step();
    check("rst_r1",  dut.R1,  64'h0);
    check("rst_r5",  dut.R5,  64'h0);
    check("rst_mdr", dut.MDR, 64'h0);
    check("rst_pc",  dut.PC,  64'h0);
    check("rst_y",   dut.Y,   64'h0);
    check("rst_lo",  dut.LO,  64'h0);
    check("rst_z",   dut.Z,   64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 Ports, in this positional order, SHALL be:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous active-high reset
- Read  in  1  MDR takes Mdatain instead of bus
- Write  in  1  memory-write strobe; no internal effect
- IncPC  in  1  PC increment qualifier
- R0_15_enable  in  16  direct register write enables, bit n = Rn
- R0_15_out  in  16  direct register bus drives, bit n = Rn
- PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin, OutPortin  in  1 each  register load enables
- PCout, Zhighout, Zlowout, HIout, LOout, MDRout, InPortout, Cout  in  1 each  bus drive selects
- BAout  in  1  base-address read: R0 reads as 0
- CONin  in  1  load CON flip-flop
- Gra, Grb, Grc  in  1 each  select IR Ra/Rb/Rc field
- Rin, Rout  in  1 each  write/drive the register chosen by Gra/Grb/Grc
- InPort_input  in  32  external input-port data
- Mdatain  in  32  memory read data
REQ-002 One clock domain; all state updates on rising Clock; reset is synchronous and active-high.

Function
REQ-003 Internal state SHALL be: R0..R15, PC, IR, MAR, MDR, Y, HI, LO, InPort, OutPort (32-bit each), Z (64-bit, ZHI/ZLO), CON (1-bit); names SHALL be as listed for hierarchical probing.
REQ-004 The 32-bit bus SHALL be a mux; priority when several drives are set: Rn (lowest n first), HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout; no drive gives 0.
REQ-005 IR fields: opcode=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15], C2=IR[20:19], C=sign-extend(IR[18:0]); Cout drives C.
REQ-006 Select/encode: selected index = OR of (Gra&Ra),(Grb&Rb),(Grc&Rc); register n written when R0_15_enable[n] | (Rin & index==n); driven when R0_15_out[n] | (Rout & index==n).
REQ-007 R0 drive SHALL output 0 when BAout=1, else R0 content.
REQ-008 MDR loads on MDRin: Mdatain if Read=1, else bus; MAR, Y, IR, HI, LO, OutPort load bus on respective enable; InPort loads InPort_input every cycle.
REQ-009 PC: PCin&IncPC -> PC+1; PCin alone -> bus.
REQ-010 ALU: A=Y, B=bus, op=IR[31:27]; Z loads ALU result when Zin; 32-bit results go to ZLO with ZHI=0.
REQ-011 Ops: 00011 add, 01100 addi, 00000/00001/00010 ld/ldi/st address add: A+B; 00100 sub A-B; 00101/01101 and; 00110/01110 or; 00111 shr logical; 01000 shra; 01001 shl; 01010 ror; 01011 rol (amount B[4:0]); 01111 mul signed 64-bit {HI,LO}; 10000 div signed, ZLO=quotient, ZHI=remainder; 10001 neg -B; 10010 not ~B; other opcodes pass B.
REQ-012 Division by zero: Z=0. Add/sub wrap modulo 2^32; no flags.
REQ-013 CON loads on CONin: C2=00 bus==0, 01 bus!=0, 10 bus[31]==0, 11 bus[31]==1.
REQ-014 Loads with simultaneous enables to different registers SHALL all occur in the same edge from the same bus value.

Reset
REQ-015 Reset=1 at a rising edge clears every internal register (R0..R15, PC, IR, MAR, MDR, Y, Z, HI, LO, InPort, OutPort, CON) to 0, overriding all enables.
REQ-016 Reset deasserted: state held unless enabled.

Verification
REQ-017 Mdatain=0x12, Read+MDRin edge; MDRout+R0_15_enable=0x0002 edge -> R1=0x12.
REQ-018 R3=0x14; IR=0x611FFFFD; Grb+Rout+Yin; Cout+Zin; Zlowout+Gra+Rin -> Y=0x14, ZLO=0x11, R2=0x11.
REQ-019 PC=5; PCout+MARin edge -> MAR=5; PCin+IncPC edge -> PC=6.
REQ-020 Y=0xFFFFFFFE, bus=3, mul, Zin -> Z=0xFFFFFFFF_FFFFFFFA; div 7 by 0 -> Z=0.
REQ-021 BAout+R0_15_out[0] with R0=0x55 -> bus 0; C2=01 bus=0 CONin -> CON=0.
REQ-022 Reset pulse mid-sequence -> all registers 0 next edge.
